router_fsm_ctrl: RTL and testbench
==================================

# router_fsm_ctrl

Packet-level write controller for the 1x3 router. It accepts a byte stream from the source port, decodes the header, and selects one of three output FIFOs. It sequences header-tag (lfd) timing, payload and parity writes into the selected FIFO, back-pressures the source on FIFO full, and checks parity. It also runs per-port read-timeout timers that soft-reset FIFOs nobody drains.

## Interface
- TIMEOUT, 30: consecutive non-empty, unread cycles before a port's soft_reset pulses.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- pkt_valid  in  1  source byte on data_in is valid.
- data_in  in  8  source byte: header, then payload, then parity.
- fifo_full  in  3  per-FIFO full.
- fifo_empty  in  3  per-FIFO empty.
- read_enb  in  3  per-FIFO read strobe from the output ports (timers only).
- data_out  out  8  byte to all FIFO data inputs.
- write_enb  out  3  one-hot FIFO write strobe.
- lfd_state  out  1  header tag; high one cycle before the header write.
- busy  out  1  source must hold data_in/pkt_valid while high.
- soft_reset  out  3  per-FIFO one-cycle soft-reset pulse, registered.
- parity_err  out  1  one-cycle pulse, registered.
- pkt_drop  out  1  one-cycle pulse, registered.

## Operation
- Header format: data_in[1:0] is addr (3 is invalid); data_in[7:2] is len (0 is invalid).
- Packet on the wire: header, then len payload bytes, then parity. Parity is the XOR of the header and all payload bytes.
- A byte is accepted in a cycle where pkt_valid=1 and busy=0.
- pkt_valid is low for at least one cycle between packets.
- The controller holds these registers: hdr_reg, addr, remaining (6b), parity_acc (8b).
- States (Moore busy and lfd_state):
  - IDLE: busy=0. On an accepted byte, latch hdr_reg, addr, remaining=len, parity_acc=data_in.
    - If addr=3 or len=0, go to DROP.
    - Else if fifo_empty[addr], go to LOAD_FIRST.
    - Else go to WAIT_EMPTY.
  - WAIT_EMPTY: busy=1. Go to LOAD_FIRST when fifo_empty[addr]=1.
  - LOAD_FIRST: busy=1, lfd_state=1, no write. Go to LOAD_HDR.
  - LOAD_HDR: busy=1. write_enb[addr]=1, data_out=hdr_reg. Go to LOAD_DATA.
  - LOAD_DATA: busy=fifo_full[addr]. On an accepted byte:
    - write_enb[addr]=1 and data_out=data_in, same cycle (combinational).
    - parity_acc^=data_in; remaining-=1.
    - When remaining goes 1→0, go to LOAD_PARITY.
  - LOAD_PARITY: busy=fifo_full[addr]. On an accepted byte:
    - Write it to the FIFO.
    - If parity_acc^data_in≠0, pulse parity_err next cycle.
    - Go to IDLE.
  - DROP: busy=0. Discard bytes, no writes. Go to IDLE on the first cycle with pkt_valid=0.
- pkt_drop pulses the cycle after any entry into DROP.
- Outside the write cycles above, write_enb=0 and data_out=0.
- Timers, one per port i (5b counter):
  - Increment when fifo_empty[i]=0 and read_enb[i]=0.
  - Clear when read_enb[i]=1 or fifo_empty[i]=1.
  - When the count reaches TIMEOUT-1, soft_reset[i] pulses next cycle and the counter clears.
- Soft reset of the active port (soft_reset[addr]=1 in WAIT_EMPTY, LOAD_FIRST, LOAD_HDR, LOAD_DATA or LOAD_PARITY):
  - write_enb is forced 0 that cycle.
  - The FSM goes to DROP.
  - pkt_drop pulses.
- Soft reset of a non-active port does not affect the FSM.

## Timing
- Reset: state=IDLE, all registers 0, all outputs 0 (busy=0, lfd_state=0). Reset mid-packet abandons it; the source restarts.
- Header accepted at cycle t:
  - lfd_state=1 at t+1.
  - Header write at t+2.
  - First payload byte can be accepted at t+3.
  - busy=1 at t+1 and t+2.
- lfd_state precedes the header write by exactly one cycle; the FIFO's one-cycle lfd delay tags the header.
- With no full stalls, a len-N packet occupies N+4 cycles from header to parity.
- fifo_full high in LOAD_DATA or LOAD_PARITY:
  - busy=1 in the same cycle.
  - No write that cycle.
  - The byte is held by the source and written in the first cycle fifo_full drops.
- parity_err and pkt_drop are asserted only for single-cycle pulses, never back-to-back for one packet.
- The remaining counter never wraps, because len≥1 is enforced at decode.

## Structure
- router_pkg holds:
  - the state enum;
  - header field constants (ADDR_LSB=0, LEN_LSB=2);
  - ADDR_INVALID=2'd3;
  - the TIMEOUT default.
- Sub-module router_sreset_timer (counter plus pulse) is instantiated three times. FSM and datapath stay in router_fsm_ctrl.

## Test plan
- Header 0x0D (addr 1, len 3), payload 11/22/33, parity 0x0D, fifo_empty=7:
  - lfd_state at t+1 and header write_enb=3'b010 at t+2.
  - Then four writes (11, 22, 33, 0D).
  - parity_err=0.
- Same packet with parity 0x0E → the parity byte is still written, and parity_err pulses once.
- Header 0x0F (addr 3) followed by 3 bytes → no write_enb, pkt_drop pulses, back in IDLE after pkt_valid=0.
- Header to addr 0 with fifo_empty[0]=0 → busy stays 1 in WAIT_EMPTY until fifo_empty[0]=1, then the normal sequence follows.
- len 20 to addr 2 with fifo_full[2] forced high for 5 cycles mid-payload → busy=1 for those cycles, no bytes lost or duplicated, exactly 22 bytes written.
- fifo_empty[1]=0 and read_enb[1]=0 for 30 cycles → soft_reset[1] pulses on cycle 31.
  - Run it during an active addr-1 packet: write suppressed, DROP entered, pkt_drop pulses.
  - A read_enb[1] at cycle 29 clears the count, and no pulse occurs.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router write path.
package router_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 30;

    localparam int unsigned ADDR_LSB     = 0;
    localparam int unsigned LEN_LSB      = 2;
    localparam logic [1:0]  ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_EMPTY,
        ST_LOAD_FIRST,
        ST_LOAD_HDR,
        ST_LOAD_DATA,
        ST_LOAD_PARITY,
        ST_DROP
    } state_e;

endpackage

// File: rtl/router_sreset_timer.sv
// Per-port read timeout: counts non-empty, unread cycles and emits a
// registered one-cycle soft_reset when the port has been ignored too long.
module router_sreset_timer
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic fifo_empty,
    input  logic read_enb,
    output logic soft_reset
);

    logic [4:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (read_enb || fifo_empty) begin
            cnt_d = '0;
        end else if (cnt_q == 5'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_fsm_ctrl.sv
// Packet write controller: decodes the header, sequences lfd/header/payload/
// parity writes into the selected FIFO, checks parity, runs read timeouts.
module router_fsm_ctrl
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [7:0] data_out,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic [2:0] soft_reset,
    output logic       parity_err,
    output logic       pkt_drop
);

    state_e     state_q, state_d;
    logic [7:0] hdr_q, hdr_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] remaining_q, remaining_d;
    logic [7:0] parity_q, parity_d;
    logic       parity_err_q, parity_err_d;
    logic       pkt_drop_q, pkt_drop_d;

    logic [1:0] hdr_addr;
    logic [5:0] hdr_len;
    logic [2:0] sel;
    logic       port_full, port_empty, port_srst, accept;

    router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer0 (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty[0]),
        .read_enb(read_enb[0]), .soft_reset(soft_reset[0])
    );
    router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer1 (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty[1]),
        .read_enb(read_enb[1]), .soft_reset(soft_reset[1])
    );
    router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer2 (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty[2]),
        .read_enb(read_enb[2]), .soft_reset(soft_reset[2])
    );

    // Address 3 yields an all-zero select, so no port is ever touched for it.
    assign hdr_addr   = data_in[ADDR_LSB +: 2];
    assign hdr_len    = data_in[LEN_LSB +: 6];
    assign sel        = 3'b001 << addr_q;
    assign port_full  = |(fifo_full & sel);
    assign port_empty = |(fifo_empty & sel);
    assign port_srst  = |(soft_reset & sel);
    assign accept     = pkt_valid && !port_full;

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        parity_d     = parity_q;
        parity_err_d = 1'b0;
        busy         = 1'b0;
        lfd_state    = 1'b0;
        write_enb    = '0;
        data_out     = '0;

        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    hdr_d       = data_in;
                    addr_d      = hdr_addr;
                    remaining_d = hdr_len;
                    parity_d    = data_in;
                    if (hdr_addr == ADDR_INVALID || hdr_len == '0)
                        state_d = ST_DROP;
                    else if (|(fifo_empty & (3'b001 << hdr_addr)))
                        state_d = ST_LOAD_FIRST;
                    else
                        state_d = ST_WAIT_EMPTY;
                end
            end
            ST_WAIT_EMPTY: begin
                busy = 1'b1;
                if (port_srst)       state_d = ST_DROP;
                else if (port_empty) state_d = ST_LOAD_FIRST;
            end
            ST_LOAD_FIRST: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                state_d   = port_srst ? ST_DROP : ST_LOAD_HDR;
            end
            ST_LOAD_HDR: begin
                busy = 1'b1;
                if (port_srst) begin
                    state_d = ST_DROP;
                end else begin
                    write_enb = sel;
                    data_out  = hdr_q;
                    state_d   = ST_LOAD_DATA;
                end
            end
            ST_LOAD_DATA: begin
                busy = port_full;
                if (port_srst) begin
                    state_d = ST_DROP;
                end else if (accept) begin
                    write_enb   = sel;
                    data_out    = data_in;
                    parity_d    = parity_q ^ data_in;
                    remaining_d = remaining_q - 6'd1;
                    if (remaining_q == 6'd1) state_d = ST_LOAD_PARITY;
                end
            end
            ST_LOAD_PARITY: begin
                busy = port_full;
                if (port_srst) begin
                    state_d = ST_DROP;
                end else if (accept) begin
                    write_enb    = sel;
                    data_out     = data_in;
                    parity_err_d = (parity_q ^ data_in) != 8'h00;
                    state_d      = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!pkt_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pkt_drop_d = (state_d == ST_DROP) && (state_q != ST_DROP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            addr_q       <= '0;
            remaining_q  <= '0;
            parity_q     <= '0;
            parity_err_q <= 1'b0;
            pkt_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            parity_q     <= parity_d;
            parity_err_q <= parity_err_d;
            pkt_drop_q   <= pkt_drop_d;
        end
    end

    assign parity_err = parity_err_q;
    assign pkt_drop   = pkt_drop_q;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: packet-level model feeds an event
// queue, a negedge monitor pops and compares every DUT output event.
module tb_router_fsm_ctrl;

    localparam int TO = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic [7:0] data_out;
    logic [2:0] write_enb, soft_reset;
    logic       lfd_state, busy, parity_err, pkt_drop;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_WR, EV_PERR, EV_DROP, EV_SRST} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        int         port;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    router_fsm_ctrl #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .data_out(data_out), .write_enb(write_enb), .lfd_state(lfd_state),
        .busy(busy), .soft_reset(soft_reset), .parity_err(parity_err),
        .pkt_drop(pkt_drop)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_e k, input int port, input logic [7:0] d);
        ev_t e;
        e.kind = k; e.port = port; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_evt(input ev_kind_e k, input int port, input logic [7:0] d, input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event port %0d data 0x%0h, nothing expected at %0t", nm, port, d, $time);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, k, e.kind);
            check({nm, "_port"}, port, e.port);
            check({nm, "_data"}, d, e.data);
        end
    endtask

    // Monitor: every output event is matched in order against the model.
    initial begin
        int p;
        forever begin
            @(negedge clock);
            if (reset) continue;
            if (write_enb != 3'b000) begin
                case (write_enb)
                    3'b001:  p = 0;
                    3'b010:  p = 1;
                    3'b100:  p = 2;
                    default: p = -1;
                endcase
                expect_evt(EV_WR, p, data_out, "write");
            end else if (data_out !== 8'h00) begin
                check("data_out_idle", data_out, 8'h00);
            end
            if (parity_err) expect_evt(EV_PERR, 0, 8'h00, "parity_err");
            if (pkt_drop)   expect_evt(EV_DROP, 0, 8'h00, "pkt_drop");
            for (int i = 0; i < 3; i++)
                if (soft_reset[i]) expect_evt(EV_SRST, i, 8'h00, "soft_reset");
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall, input int port);
        int waited = 0;
        pkt_valid = 1'b1;
        data_in   = b;
        if (stall > 0) begin
            fifo_full[port] = 1'b1;
            repeat (stall) begin
                @(negedge clock);
                check("busy_on_full", busy, 1'b1);
                @(posedge clock); #1;
            end
            fifo_full[port] = 1'b0;
        end
        @(negedge clock);
        while (busy && waited < 200) begin
            @(posedge clock); #1;
            @(negedge clock);
            waited++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: busy still 1 after %0d cycles, required 0", waited);
        end
        @(posedge clock); #1;
    endtask

    // Model: a valid packet produces header, payload and parity writes to its
    // port plus a parity error if the XOR does not cancel; otherwise one drop.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par,
                               input bit rnd_stall, input int wait_cycles,
                               input int stall_idx, input int stall_len);
        int         a   = int'(hdr[1:0]);
        int         len = int'(hdr[7:2]);
        bit         ok  = (a != 3) && (len != 0);
        logic [7:0] x   = hdr;
        int         st;

        if (!ok) begin
            push(EV_DROP, 0, 8'h00);
        end else begin
            push(EV_WR, a, hdr);
            foreach (pl[i]) begin
                push(EV_WR, a, pl[i]);
                x ^= pl[i];
            end
            push(EV_WR, a, par);
            if ((x ^ par) != 8'h00) push(EV_PERR, 0, 8'h00);
        end

        if (ok && wait_cycles > 0) fifo_empty[a] = 1'b0;
        pkt_valid = 1'b1;
        data_in   = hdr;
        @(negedge clock);
        check("hdr_accept_busy", busy, 1'b0);
        @(posedge clock); #1;

        if (ok) begin
            data_in = pl[0];
            if (wait_cycles > 0) begin
                for (int k = 0; k <= wait_cycles; k++) begin
                    if (k == wait_cycles) fifo_empty[a] = 1'b1;
                    @(negedge clock);
                    check("wait_empty_busy", busy, 1'b1);
                    check("wait_empty_lfd", lfd_state, 1'b0);
                    @(posedge clock); #1;
                end
            end
            @(negedge clock);
            check("lfd_cycle", lfd_state, 1'b1);
            check("lfd_busy", busy, 1'b1);
            @(posedge clock); #1;
            @(negedge clock);
            check("hdr_wr_lfd", lfd_state, 1'b0);
            check("hdr_wr_busy", busy, 1'b1);
            @(posedge clock); #1;
            foreach (pl[i]) begin
                st = 0;
                if (i == stall_idx) st = stall_len;
                else if (rnd_stall && i > 0 && $urandom_range(0, 3) == 0) st = int'($urandom_range(1, 2));
                send_byte(pl[i], st, a);
            end
            st = (rnd_stall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_byte(par, st, a);
        end else begin
            foreach (pl[i]) send_byte(pl[i], 0, 0);
            send_byte(par, 0, 0);
        end

        pkt_valid = 1'b0;
        data_in   = 8'($urandom);
        @(negedge clock);
        check("gap_busy", busy, 1'b0);
        @(posedge clock); #1;
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr, par, x;
        int         a, len;

        reset      = 1'b1;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_lfd", lfd_state, 1'b0);
        check("rst_wr", write_enb, 3'b000);
        check("rst_dout", data_out, 8'h00);
        check("rst_srst", soft_reset, 3'b000);
        check("rst_perr", parity_err, 1'b0);
        check("rst_drop", pkt_drop, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Nominal addr-1 packet, correct then corrupted parity.
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, pl, 8'h0D, 1'b0, 0, -1, 0);
        send_packet(8'h0D, pl, 8'h0E, 1'b0, 0, -1, 0);

        // Invalid address: three trailing bytes discarded.
        pl = '{8'hA1, 8'hA2};
        send_packet(8'h0F, pl, 8'hA3, 1'b0, 0, -1, 0);

        // Zero length: header plus one byte discarded.
        pl.delete();
        send_packet(8'h01, pl, 8'h55, 1'b0, 0, -1, 0);

        // Addr 0 while its FIFO is still occupied.
        pl = '{8'h5A, 8'hC3};
        send_packet(8'h08, pl, 8'h08 ^ 8'h5A ^ 8'hC3, 1'b0, 6, -1, 0);

        // len 20 to addr 2 with a five-cycle full stall mid-payload.
        pl.delete();
        x = 8'h52;
        for (int i = 0; i < 20; i++) begin
            pl.push_back(8'(i * 7 + 3));
            x ^= 8'(i * 7 + 3);
        end
        send_packet(8'h52, pl, x, 1'b0, 0, 10, 5);

        // Idle timeout on port 1.
        push(EV_SRST, 1, 8'h00);
        fifo_empty[1] = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clock);
            check((c == 31) ? "srst_fire" : "srst_quiet", soft_reset[1], (c == 31) ? 1'b1 : 1'b0);
            @(posedge clock); #1;
        end
        fifo_empty[1] = 1'b1;
        @(negedge clock);
        check("srst_single", soft_reset[1], 1'b0);
        @(posedge clock); #1;
        check("sb_drained_srst", exp_q.size(), 0);

        // A read at cycle 29 restarts the count.
        fifo_empty[1] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            read_enb[1] = (c == 29);
            @(negedge clock);
            check("srst_read_clears", soft_reset[1], 1'b0);
            @(posedge clock); #1;
        end
        read_enb[1]   = 1'b0;
        fifo_empty[1] = 1'b1;
        @(posedge clock); #1;

        // Timeout on the active port mid-payload aborts the packet.
        push(EV_WR, 1, 8'h0D);
        push(EV_SRST, 1, 8'h00);
        push(EV_DROP, 0, 8'h00);
        pkt_valid = 1'b1;
        data_in   = 8'h0D;
        @(negedge clock);
        check("act_hdr_busy", busy, 1'b0);
        @(posedge clock); #1;
        fifo_empty[1] = 1'b0;
        pkt_valid     = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        pkt_valid = 1'b1;
        data_in   = 8'h11;
        @(negedge clock);
        check("act_srst_pulse", soft_reset[1], 1'b1);
        check("act_write_blocked", write_enb, 3'b000);
        @(posedge clock); #1;
        fifo_empty[1] = 1'b1;
        data_in       = 8'h22;
        @(negedge clock);
        check("act_drop_busy", busy, 1'b0);
        @(posedge clock); #1;
        data_in = 8'h33;
        @(posedge clock); #1;
        data_in = 8'h0D;
        @(posedge clock); #1;
        pkt_valid = 1'b0;
        @(posedge clock); #1;
        check("sb_drained_act", exp_q.size(), 0);

        // Randomised traffic.
        for (int n = 0; n < 40; n++) begin
            a   = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            hdr = {6'(len), 2'(a)};
            x   = hdr;
            pl.delete();
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                x ^= pl[i];
            end
            par = x ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            send_packet(hdr, pl, par, 1'b1,
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0, -1, 0);
        end

        repeat (3) @(posedge clock);
        check("sb_final_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
